// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for a sync header, forwards payload bits, flywheels over bad headers.
// Define FRAME_RX_PARITY_EN to expect an even-parity bit after each payload.
module serial_frame_receiver #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter int                    MISS_LIMIT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_din,
    input  logic i_din_valid,
    output logic o_dout,
    output logic o_dout_valid,
    output logic o_frame_done,
    output logic o_frame_err,
    output logic o_locked
);

    localparam int CNT_MAX = (DATA_WIDTH > SYNC_WIDTH) ? DATA_WIDTH : SYNC_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  LAST_SYNC = CNT_W'(SYNC_WIDTH - 1);
    localparam logic [MISS_W-1:0] LAST_MISS = MISS_W'(MISS_LIMIT - 1);

`ifdef FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY, SYNC} state_t;
`else
    typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC} state_t;
`endif

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [SYNC_WIDTH-1:0] shreg, shreg_n;
    logic [MISS_W-1:0]     miss, miss_n;
    logic                  dout_n, dout_valid_n, frame_done_n, frame_err_n;
`ifdef FRAME_RX_PARITY_EN
    logic                  par, par_n;
`endif

    logic                  accept;
    logic [SYNC_WIDTH-1:0] shifted;

    assign accept  = i_en & i_din_valid;
    assign shifted = {shreg[SYNC_WIDTH-2:0], i_din};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= HUNT;
            cnt          <= '0;
            shreg        <= '0;
            miss         <= '0;
            o_dout       <= 1'b0;
            o_dout_valid <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_locked     <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
            par          <= 1'b0;
`endif
        end else if (i_en) begin
            state        <= state_n;
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            miss         <= miss_n;
            o_dout       <= dout_n;
            o_dout_valid <= dout_valid_n;
            o_frame_done <= frame_done_n;
            o_frame_err  <= frame_err_n;
            o_locked     <= (state_n != HUNT);
`ifdef FRAME_RX_PARITY_EN
            par          <= par_n;
`endif
        end else begin
            // Enable low freezes state but the one-cycle qualifiers must still drop.
            o_dout_valid <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shreg_n      = shreg;
        miss_n       = miss;
        dout_n       = o_dout;
        dout_valid_n = 1'b0;
        frame_done_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef FRAME_RX_PARITY_EN
        par_n        = par;
`endif
        if (accept) begin
            case (state)
                HUNT: begin
                    shreg_n = shifted;
                    if (shifted == SYNC_WORD) begin
                        state_n = PAYLOAD;
                        cnt_n   = '0;
                    end
                end
                PAYLOAD: begin
                    dout_n       = i_din;
                    dout_valid_n = 1'b1;
                    cnt_n        = cnt + 1'b1;
`ifdef FRAME_RX_PARITY_EN
                    par_n        = par ^ i_din;
`endif
                    if (cnt == LAST_DATA) begin
                        frame_done_n = 1'b1;
                        cnt_n        = '0;
`ifdef FRAME_RX_PARITY_EN
                        state_n      = PARITY;
`else
                        state_n      = SYNC;
`endif
                    end
                end
`ifdef FRAME_RX_PARITY_EN
                PARITY: begin
                    frame_err_n = par ^ i_din;
                    par_n       = 1'b0;
                    cnt_n       = '0;
                    state_n     = SYNC;
                end
`endif
                SYNC: begin
                    shreg_n = shifted;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == LAST_SYNC) begin
                        cnt_n = '0;
                        if (shifted == SYNC_WORD) begin
                            miss_n  = '0;
                            state_n = PAYLOAD;
                        end else begin
                            frame_err_n = 1'b1;
                            // Too many misses in a row: alignment is lost, restart the search from scratch.
                            if (miss == LAST_MISS) begin
                                miss_n  = '0;
                                shreg_n = '0;
                                state_n = HUNT;
                            end else begin
                                miss_n  = miss + 1'b1;
                                state_n = PAYLOAD;
                            end
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: a frame-position reference model queues expected events.
module tb_serial_frame_receiver;

    localparam int         DW    = 24;
    localparam int         SW    = 8;
    localparam int         ML    = 2;
    localparam logic [7:0] SWORD = 8'hA5;
`ifdef FRAME_RX_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int FL = DW + PW + SW;

    logic clk = 1'b0;
    logic rst, en, din, din_valid;
    logic dout, dout_valid, frame_done, frame_err, locked;

    always #5 clk = ~clk;

    serial_frame_receiver dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err),
        .o_locked     (locked)
    );

    typedef struct packed {
        logic err;
        logic b;
        logic done;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    logic       m_locked;
    logic [7:0] m_win;
    logic [7:0] m_hdr;
    logic       m_par;
    logic       hold_bit;
    int         m_pos;
    int         m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_win    = 8'h00;
        m_hdr    = 8'h00;
        m_par    = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
        hold_bit = 1'b0;
        exp_q.delete();
    endfunction

    // Reference: position within a locked frame decides whether a bit is payload, parity or header.
    function automatic void model_bit(input logic b);
        ev_t e;
        if (!m_locked) begin
            m_win = {m_win[6:0], b};
            if (m_win == SWORD) begin
                m_locked = 1'b1;
                m_pos    = 0;
                m_par    = 1'b0;
                m_hdr    = 8'h00;
            end
            return;
        end
        if (m_pos < DW) begin
            e.err  = 1'b0;
            e.b    = b;
            e.done = (m_pos == DW - 1);
            exp_q.push_back(e);
            m_par = m_par ^ b;
        end else if (m_pos < DW + PW) begin
            if (m_par ^ b) begin
                e = '{err: 1'b1, b: 1'b0, done: 1'b0};
                exp_q.push_back(e);
            end
        end else begin
            m_hdr = {m_hdr[6:0], b};
            if (m_pos == FL - 1) begin
                if (m_hdr == SWORD) begin
                    m_miss = 0;
                end else begin
                    e = '{err: 1'b1, b: 1'b0, done: 1'b0};
                    exp_q.push_back(e);
                    m_miss++;
                    if (m_miss == ML) begin
                        m_locked = 1'b0;
                        m_win    = 8'h00;
                        m_miss   = 0;
                    end
                end
            end
        end
        m_pos++;
        if (m_pos == FL) begin
            m_pos = 0;
            m_par = 1'b0;
            m_hdr = 8'h00;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst && en && din_valid) model_bit(din);
    end

    // Monitor: pop one expectation per presented output event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            chk("locked", 32'(locked), 32'(m_locked));
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dout_valid", 32'(dout_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_data", 32'(e.err), 32'd0);
                    chk("dout_bit", 32'(dout), 32'(e.b));
                    chk("frame_done", 32'(frame_done), 32'(e.done));
                    hold_bit = e.b;
                end
            end else begin
                chk("dout_hold", 32'(dout), 32'(hold_bit));
                chk("done_without_valid", 32'(frame_done), 32'd0);
            end
            if (frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_err", 32'(frame_err), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_err", 32'(e.err), 32'd1);
                end
            end
        end
    end

    task automatic cyc(input logic e, input logic v, input logic d);
        @(posedge clk);
        #1;
        en        = e;
        din_valid = v;
        din       = d;
    endtask

    task automatic send_bit(input logic d);
        logic ge;
        if ($urandom_range(0, 3) == 0) begin
            ge = 1'($urandom);
            cyc(ge, ge ? 1'b0 : 1'($urandom), 1'($urandom));
        end
        cyc(1'b1, 1'b1, d);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic noise(input int n);
        logic [7:0] w;
        logic       b;
        w = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            if ({w[6:0], b} == SWORD) b = ~b;
            w = {w[6:0], b};
            send_bit(b);
        end
    endtask

    task automatic send_parity(input logic [23:0] p, input logic ok);
        if (PW != 0) send_bit(ok ? ^p : ~^p);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [23:0] p, input logic ok);
        send_word(32'(hdr), 8);
        send_word(32'(p), 24);
        send_parity(p, ok);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        logic [23:0] p;
        logic [7:0]  h;
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        // Acquisition from noise, then the reference frame.
        noise(40);
        send_frame(SWORD, 24'h123456, 1'b1);
        send_frame(SWORD, 24'($urandom), 1'b1);

`ifdef FRAME_RX_PARITY_EN
        send_frame(SWORD, 24'h123456, 1'b0);
        send_frame(SWORD, 24'h0F0F0F, 1'b1);
`endif

        // Single bad header flywheels, two in a row drop lock.
        send_frame(8'hA4, 24'hABCDEF, 1'b1);
        send_frame(SWORD, 24'h55AA33, 1'b1);
        send_frame(8'hA4, 24'h13579B, 1'b1);
        send_word(32'h0000_00A4, 8);
        noise(30);
        send_frame(SWORD, 24'h2468AC, 1'b1);

        // Enable gap in the middle of a payload.
        p = 24'hC3A51E;
        send_word(32'(SWORD), 8);
        send_word(32'(p[23:12]), 12);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'(k % 2), 1'($urandom));
            @(negedge clk);
            if (k > 0) chk("gap_dout_valid", 32'(dout_valid), 32'd0);
        end
        send_word(32'(p[11:0]), 12);
        send_parity(p, 1'b1);

        // Reset mid-payload, then a headerless tail, then a clean frame.
        p = 24'h9E3779;
        send_word(32'(SWORD), 8);
        send_word(32'(p[23:14]), 10);
        @(posedge clk);
        #2;
        rst       = 1'b1;
        en        = 1'b1;
        din_valid = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(32'(p[13:0]), 14);
        noise(20);
        send_frame(SWORD, 24'h123456, 1'b1);

        // Randomized frames with occasional bad headers and parity.
        for (int f = 0; f < 12; f++) begin
            h = ($urandom_range(0, 4) == 0) ? 8'($urandom) : SWORD;
            send_frame(h, 24'($urandom), ($urandom_range(0, 3) != 0));
        end

        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, payload bits per frame (matches the downstream deserializer LENGTH).
REQ-002 SHALL have parameter SYNC_WIDTH, default 8, sync header length in bits.
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5, expected header value, SYNC_WIDTH bits.
REQ-004 SHALL have parameter MISS_LIMIT, default 2, consecutive bad headers before lock is dropped.
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_en  input  1  global enable; low freezes all state.
REQ-008 SHALL have port i_din  input  1  raw serial line bit.
REQ-009 SHALL have port i_din_valid  input  1  i_din qualifier; a bit is accepted when i_en and i_din_valid are both high.
REQ-010 SHALL have port o_dout  output  1  forwarded payload bit.
REQ-011 SHALL have port o_dout_valid  output  1  o_dout qualifier, one cycle per payload bit.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse with the last payload bit of each frame.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse on a header mismatch or parity failure.
REQ-014 SHALL have port o_locked  output  1  high when frame alignment is held.

Function
REQ-015 SHALL implement states HUNT, PAYLOAD, PARITY, SYNC; only accepted bits advance state or counters.
REQ-016 SHALL, in HUNT, shift each accepted bit into a SYNC_WIDTH-bit register, MSB-first, and go to PAYLOAD on the accepted bit that makes the register equal SYNC_WORD.
REQ-017 SHALL, in PAYLOAD, forward each accepted bit to o_dout with o_dout_valid high exactly one cycle after acceptance, MSB-first.
REQ-018 SHALL leave PAYLOAD after DATA_WIDTH accepted bits, going to PARITY (macro defined) or SYNC (macro undefined).
REQ-019 SHALL assert o_frame_done in the same cycle as o_dout_valid for payload bit DATA_WIDTH-1.
REQ-020 SHALL, in SYNC, collect SYNC_WIDTH accepted bits and compare them with SYNC_WORD when the last one is accepted.
REQ-021 SHALL, on a header match, clear the miss counter and go to PAYLOAD.
REQ-022 SHALL, on a header mismatch, pulse o_frame_err one cycle after the last header bit and increment the miss counter.
REQ-023 SHALL go to PAYLOAD (flywheel) after a mismatch while the miss count is below MISS_LIMIT.
REQ-024 SHALL, when the miss count reaches MISS_LIMIT, go to HUNT, clear the miss counter and clear the hunt shift register.
REQ-025 SHALL drive o_locked low in HUNT and high in PAYLOAD, PARITY and SYNC, registered with state.
REQ-026 SHALL deassert o_dout_valid in any cycle with no accepted payload bit, including i_en low.
REQ-027 SHALL hold o_dout at its last value when o_dout_valid is low.
REQ-028 SHALL ignore i_din_valid while i_en is low; no bit is lost or duplicated across an i_en gap.
REQ-029 SHALL forward no bits while in HUNT, SYNC or PARITY.

Reset
REQ-030 SHALL on i_rst asynchronously force: state HUNT, counters 0, shift register 0, o_dout 0, o_dout_valid 0, o_frame_done 0, o_frame_err 0, o_locked 0.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame; after release, a full header is required before any output.

Configuration
REQ-032 SHALL, with FRAME_RX_PARITY_EN defined, expect one even-parity bit after the payload, so that the XOR of the payload and parity bits is 0.
REQ-033 SHALL, with FRAME_RX_PARITY_EN defined, pulse o_frame_err one cycle after the parity bit is accepted when parity fails, then go to SYNC; lock is unaffected.
REQ-034 SHALL, without FRAME_RX_PARITY_EN, omit the PARITY state and go directly from PAYLOAD to SYNC.

Verification
REQ-035 SHALL test: random bits containing no A5 pattern, then A5, then 24'h123456 (+ parity 1 with macro) -> o_locked high after header, 24 valid bits 0x123456 MSB-first, o_frame_done on the 24th bit, no o_frame_err.
REQ-036 SHALL test (macro defined): the same frame with parity bit 0 -> single o_frame_err pulse, o_locked stays high, next A5 frame accepted.
REQ-037 SHALL test: locked stream, one header 0xA4 -> o_frame_err pulse and the next payload is still forwarded; two consecutive bad headers -> o_locked low, HUNT, no o_dout_valid until the next A5.
REQ-038 SHALL test: i_en low for 5 cycles mid-payload with i_din_valid toggling -> no o_dout_valid during the gap, and the payload bits resume intact.
REQ-039 SHALL test: i_rst asserted after payload bit 10 -> all outputs 0 immediately; the stream resumed without a header yields no output; a full A5 frame after that decodes correctly.
